// File: rtl/coin_credit_pkg.sv
// Shared types and helpers for the coin credit unit: FSM states, default coin
// weights and a clipping adder used for both credit and change arithmetic.
package coin_credit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_e;

  localparam int N_COINS_DEF  = 2;
  localparam int VALUE_W_DEF  = 4;
  localparam int CREDIT_W_DEF = 8;
  localparam logic [N_COINS_DEF*VALUE_W_DEF-1:0] COIN_VALUES_DEF = {4'd5, 4'd1};

  // a + b clipped to max_v; one spare bit so the carry never wraps
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max_v}) begin
      return max_v;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/coin_credit_unit_if.sv
// Bundle of button, purchase and change-handshake signals between the board
// controls / dispenser logic (master) and the coin credit unit (slave).
interface coin_credit_unit_if #(
  parameter int N_COINS  = 2,
  parameter int CREDIT_W = 8
);
  logic [N_COINS-1:0]  coin_in;
  logic [CREDIT_W-1:0] price;
  logic                buy;
  logic                cancel;
  logic                change_ack;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                deny;
  logic                coin_reject;
  logic                saturated;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;

  modport master (
    output coin_in, price, buy, cancel, change_ack,
    input  credit, dispense, deny, coin_reject, saturated, change_valid, change_amount
  );

  modport slave (
    input  coin_in, price, buy, cancel, change_ack,
    output credit, dispense, deny, coin_reject, saturated, change_valid, change_amount
  );
endinterface

// File: rtl/coin_edge_detect.sv
// Per-channel two-flop synchroniser followed by a registered rising-edge
// detector; each press yields exactly one single-cycle pulse on edge_o.
module coin_edge_detect #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] edge_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        prev_q  <= 1'b0;
        edge_q  <= 1'b0;
      end else begin
        sync1_q <= raw_i[gi];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
        edge_q  <= sync2_q & ~prev_q;
      end
    end

    assign edge_o[gi] = edge_q;
  end

endmodule

// File: rtl/coin_credit_unit.sv
// Coin credit unit: weighted coin accumulation with clipping, plus the
// buy/cancel FSM that dispenses and hands back change over a valid/ack pair.
module coin_credit_unit
  import coin_credit_pkg::*;
#(
  parameter int N_COINS  = N_COINS_DEF,
  parameter int VALUE_W  = VALUE_W_DEF,
  parameter logic [N_COINS*VALUE_W-1:0] COIN_VALUES = COIN_VALUES_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  coin_credit_unit_if.slave bus
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [31:0] CRED_MAX = 32'((33'd1 << CREDIT_W) - 33'd1);

  logic [N_COINS-1:0]  coin_edge;
  logic [SUM_W-1:0]    coin_sum;
  logic [CREDIT_W-1:0] credit_add;
  logic                add_ovf;
  logic [CREDIT_W-1:0] remainder;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                saturated_q, saturated_d;
  logic                deny_q, deny_d;
  logic                reject_q, reject_d;

  coin_edge_detect #(.WIDTH(N_COINS)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (bus.coin_in),
    .edge_o (coin_edge)
  );

  always_comb begin
    coin_sum = '0;
    for (int i = 0; i < N_COINS; i++) begin
      if (coin_edge[i]) begin
        coin_sum = coin_sum + SUM_W'(COIN_VALUES[i*VALUE_W +: VALUE_W]);
      end
    end
  end

  assign credit_add = CREDIT_W'(sat_add(32'(credit_q), 32'(coin_sum), CRED_MAX));
  assign add_ovf    = (32'(credit_q) + 32'(coin_sum)) > CRED_MAX;
  // credit_q already covers the price here: it was checked before the buy was taken
  assign remainder  = CREDIT_W'(sat_add(32'(credit_q) - 32'(price_q), 32'(coin_sum), CRED_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      change_q    <= '0;
      saturated_q <= 1'b0;
      deny_q      <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      price_q     <= price_d;
      change_q    <= change_d;
      saturated_q <= saturated_d;
      deny_q      <= deny_d;
      reject_q    <= reject_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    price_d     = price_q;
    change_d    = change_q;
    saturated_d = saturated_q;
    deny_d      = 1'b0;
    reject_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        credit_d = credit_add;
        if (add_ovf) begin
          saturated_d = 1'b1;
        end
        if (bus.buy && (bus.price != '0) && (credit_q >= bus.price)) begin
          price_d = bus.price;
          state_d = DISPENSE;
        end else if (bus.cancel) begin
          // a coin landing on the cancel cycle is refunded rather than lost
          if (credit_q != '0) begin
            change_d = credit_add;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end else if (bus.buy) begin
          deny_d = 1'b1;
        end
      end
      DISPENSE: begin
        credit_d = '0;
        if (remainder != '0) begin
          change_d = remainder;
          state_d  = CHANGE;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        credit_d = '0;
        reject_d = |coin_edge;
        if (bus.change_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (credit_d == '0) begin
      saturated_d = 1'b0;
    end
  end

  assign bus.credit        = credit_q;
  assign bus.dispense      = (state_q == DISPENSE);
  assign bus.deny          = deny_q;
  assign bus.coin_reject   = reject_q;
  assign bus.saturated     = saturated_q;
  assign bus.change_valid  = (state_q == CHANGE);
  assign bus.change_amount = change_q;

endmodule
